// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the shift/display peripheral bus.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_SHIFT   = 3'b011;
  localparam logic [2:0] ADDR_CTRL    = 3'b100;
  localparam int         CTRL_DISPLAY = 0;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state timer: counts ACCESS cycles and flags expiry on the TIMEOUT-th one.
// TIMEOUT = 0 disables the timer entirely.
module bus_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT > 0) begin : g_timer
    localparam int            CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and saturate at MAX.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != MAX)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    // Expire during the cycle that would be the TIMEOUT-th enabled one.
    assign expire = enable && (cnt_q == MAX);
  end else begin : g_none
    logic unused_inputs;
    assign unused_inputs = CLK ^ RESET ^ clear ^ enable;
    assign expire        = 1'b0;
  end

endmodule

// File: rtl/periph_bus_initiator.sv
// Host-request to two-phase SEL/EN/W bus initiator with read bursts and
// wait-state timeout. All bus and response outputs are registered.
module periph_bus_initiator
  import periph_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              SEL,
  output logic              EN,
  output logic              W,
  output logic [2:0]        rel_addr,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  state_t              state_q, state_d;
  logic                sel_q, sel_d, en_q, en_d, w_q, w_d;
  logic [2:0]          addr_q, addr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                expire;

  assign req_ready = (state_q == IDLE) && !RESET;

  // Wait counter is cleared while in SETUP so every ACCESS starts from zero.
  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (state_q == SETUP),
    .enable (state_q == ACCESS),
    .expire (expire)
  );

  // Next state and registered outputs; PREADY has priority over timeout.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_d        = en_q;
    w_d         = w_q;
    addr_d      = addr_q;
    pwdata_d    = pwdata_q;
    beat_d      = beat_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = SETUP;
          sel_d    = 1'b1;
          en_d     = 1'b0;
          w_d      = req_write;
          addr_d   = req_addr;
          pwdata_d = req_wdata;
          beat_d   = req_write ? '0 : req_len;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        en_d    = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = w_q ? '0 : PRDATA;
          if (beat_q != '0) begin
            beat_d  = beat_q - LEN_W'(1);
            state_d = SETUP;
            en_d    = 1'b0;
          end else begin
            state_d = IDLE;
            sel_d   = 1'b0;
            en_d    = 1'b0;
            w_d     = 1'b0;
          end
        end else if (expire) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          beat_d      = '0;
          state_d     = IDLE;
          sel_d       = 1'b0;
          en_d        = 1'b0;
          w_d         = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        en_d    = 1'b0;
        w_d     = 1'b0;
      end
    endcase
  end

  // State, bus and response registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      en_q        <= 1'b0;
      w_q         <= 1'b0;
      addr_q      <= '0;
      pwdata_q    <= '0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      w_q         <= w_d;
      addr_q      <= addr_d;
      pwdata_q    <= pwdata_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign SEL       = sel_q;
  assign EN        = en_q;
  assign W         = w_q;
  assign rel_addr  = addr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
